// File: rtl/riscv_mul_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mul_pkg
// Shared definitions for the iterative RV32M multiplier in the EX stage:
//   - funct encodings for MUL / MULH / MULHSU / MULHU
//   - FSM state encoding (2 bits)
//   - iteration count of the radix-2 shift-add loop
// -----------------------------------------------------------------------------
package riscv_mul_pkg;

   localparam logic [1:0] MUL_LO  = 2'b00;  // MUL    : low word, signed x signed
   localparam logic [1:0] MUL_HSS = 2'b01;  // MULH   : high word, signed x signed
   localparam logic [1:0] MUL_HSU = 2'b10;  // MULHSU : high word, signed x unsigned
   localparam logic [1:0] MUL_HUU = 2'b11;  // MULHU  : high word, unsigned x unsigned

   localparam int MUL_ITER = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2,
      ST_DONE = 2'd3
   } mul_state_e;

   // Magnitude of a 32-bit value. For a signed operand 0x80000000 the negation
   // wraps back to 0x80000000, which is the correct unsigned magnitude.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/ex_mul_unit.sv
// -----------------------------------------------------------------------------
// ex_mul_unit
// Iterative 32x32 multiplier for RV32M MUL/MULH/MULHSU/MULHU in the EX stage.
// Operands are converted to magnitudes, multiplied by a 32-step LSB-first
// shift-add loop, sign-corrected, and the selected half is registered.
// Fixed latency: start seen at edge k -> mul_done high in the cycle after k+33.
//
// Ports:
//   clk           in   pipeline clock
//   reset         in   synchronous, active-low clear
//   mul_start     in   multiply request (registered ID/EX activate bit)
//   mul_kill      in   pipeline flush, aborts the op in flight
//   mul_funct     in   00=MUL 01=MULH 10=MULHSU 11=MULHU
//   op_a, op_b    in   rs1 / rs2 values
//   rd_in         in   destination register
//   mul_stall     out  hold PC, IF/ID, ID/EX (combinational)
//   mul_done      out  one-cycle result strobe
//   mul_result    out  selected product half (registered, held)
//   mul_rd        out  destination of mul_result (registered, held)
//   mul_reg_write out  same as mul_done
// -----------------------------------------------------------------------------
module ex_mul_unit
   import riscv_mul_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mul_start,
   input  logic            mul_kill,
   input  logic [1:0]      mul_funct,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   output logic            mul_stall,
   output logic            mul_done,
   output logic [XLEN-1:0] mul_result,
   output logic [4:0]      mul_rd,
   output logic            mul_reg_write
);

   mul_state_e          state_q,  state_d;
   logic [4:0]          cnt_q,    cnt_d;
   logic [2*XLEN-1:0]   acc_q,    acc_d;
   logic [2*XLEN-1:0]   mcand_q,  mcand_d;   // multiplicand magnitude, shifts left
   logic [XLEN-1:0]     mplier_q, mplier_d;  // multiplier magnitude, shifts right
   logic                neg_q,    neg_d;
   logic [1:0]          funct_q,  funct_d;
   logic [4:0]          rd_q,     rd_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic [4:0]          rd_out_q, rd_out_d;

   logic                a_signed, b_signed;
   logic [2*XLEN-1:0]   prod_fix;

   assign a_signed = (mul_funct != MUL_HUU);
   assign b_signed = (mul_funct == MUL_LO) || (mul_funct == MUL_HSS);

   // Negating a zero accumulator yields zero, so no negative-zero artefact.
   assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      neg_d     = neg_q;
      funct_d   = funct_q;
      rd_d      = rd_q;
      result_d  = result_q;
      rd_out_d  = rd_out_q;
      mul_stall = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            mul_stall = mul_start;
            if (mul_start && !mul_kill) begin
               state_d  = ST_CALC;
               cnt_d    = '0;
               acc_d    = '0;
               mcand_d  = {{XLEN{1'b0}}, mag32(op_a, a_signed)};
               mplier_d = mag32(op_b, b_signed);
               neg_d    = (a_signed & op_a[XLEN-1]) ^ (b_signed & op_b[XLEN-1]);
               funct_d  = mul_funct;
               rd_d     = rd_in;
            end
         end
         ST_CALC: begin
            mul_stall = 1'b1;
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'(MUL_ITER - 1)) begin
               state_d = ST_SIGN;
            end
         end
         ST_SIGN: begin
            mul_stall = 1'b1;
            result_d  = (funct_q == MUL_LO) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            rd_out_d  = rd_q;
            state_d   = ST_DONE;
         end
         ST_DONE: begin
            // ID/EX still holds this instruction; its start must not retrigger.
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A flush abandons the op without touching the held result registers.
      if (mul_kill && (state_q != ST_IDLE)) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         result_d = result_q;
         rd_out_d = rd_out_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         funct_q  <= MUL_LO;
         rd_q     <= '0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         funct_q  <= funct_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
      end
   end

   // The DONE state is itself registered, so a kill arriving in DONE cannot
   // suppress the strobe.
   assign mul_done      = (state_q == ST_DONE);
   assign mul_reg_write = mul_done;
   assign mul_result    = result_q;
   assign mul_rd        = rd_out_q;

endmodule
